// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the PC sequencer slice.
//   PCSEQ_PC_WIDTH  : default program counter width in bits
//   PCSEQ_RAS_DEPTH : default return-address-stack depth (power of two, >= 2)
//   pcseq_state_t   : sequencer FSM states (RUN, FLUSH, HALT)
// -----------------------------------------------------------------------------
package cpu_pkg;

  localparam int PCSEQ_PC_WIDTH  = 6;
  localparam int PCSEQ_RAS_DEPTH = 4;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    HALT  = 2'd2
  } pcseq_state_t;

endpackage

// File: rtl/pcseq_ras.sv
// -----------------------------------------------------------------------------
// pcseq_ras
// Circular return-address stack. A push onto a full stack overwrites the
// oldest entry, so the newest DEPTH return addresses are always kept.
// Push and pop are never requested in the same cycle by the sequencer.
// Ports:
//   clk, reset : clock and synchronous active-high reset (empties the stack)
//   i_push     : write i_data as the new top
//   i_pop      : discard the current top
//   i_data     : return address to push
//   o_top      : current top-of-stack value
//   o_full     : DEPTH entries held
//   o_empty    : no entries held
// -----------------------------------------------------------------------------
module pcseq_ras #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_top,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   CNT_MAX = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W:0]   r_count;

  // The write pointer always names the slot the next push lands in. When the
  // stack is full that slot holds the oldest entry, which gives the circular
  // overwrite for free; the count simply saturates at DEPTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wrPtr <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_push) begin
      r_mem[r_wrPtr] <= i_data;
      r_wrPtr        <= r_wrPtr + PTR_ONE;
      if (r_count != CNT_MAX) begin
        r_count <= r_count + CNT_ONE;
      end
    end else if (i_pop && (r_count != '0)) begin
      r_wrPtr <= r_wrPtr - PTR_ONE;
      r_count <= r_count - CNT_ONE;
    end
  end

  // Top of stack sits one slot behind the write pointer (wraps modulo DEPTH).
  always_comb begin
    o_top   = r_mem[r_wrPtr - PTR_ONE];
    o_full  = (r_count == CNT_MAX);
    o_empty = (r_count == '0);
  end

endmodule

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
// Fetch sequencer: decides each cycle whether the PC increments, loads a
// branch/call/return target, or holds, and squashes the wrongly fetched
// instruction with a one-cycle FLUSH after every redirect.
// Optional feature: define PC_SEQ_CALL_STACK_EN to build the return-address
// stack (pcseq_ras). Without it call_req behaves as br_req, ret_req is
// ignored and ras_err is tied low.
// Ports:
//   clk, reset     : clock and synchronous active-high reset
//   pc             : current PC value (return address = pc + 1)
//   stall_req      : datapath busy, freeze fetch
//   br_req         : taken branch/jump, target on br_target
//   br_target      : target for br_req and call_req
//   call_req       : subroutine call
//   ret_req        : subroutine return
//   halt_req       : enter HALT
//   resume         : leave HALT
//   PCincr         : PC increment enable
//   branch_en      : PC load enable
//   branch_target  : value the PC loads (0 when branch_en=0)
//   flush          : squash fetched instruction (state FLUSH)
//   halted         : state HALT
//   ras_err        : sticky stack overflow/underflow flag
// -----------------------------------------------------------------------------
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter int PC_WIDTH  = PCSEQ_PC_WIDTH,
  parameter int RAS_DEPTH = PCSEQ_RAS_DEPTH
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [PC_WIDTH-1:0] pc,
  input  logic                stall_req,
  input  logic                br_req,
  input  logic [PC_WIDTH-1:0] br_target,
  input  logic                call_req,
  input  logic                ret_req,
  input  logic                halt_req,
  input  logic                resume,
  output logic                PCincr,
  output logic                branch_en,
  output logic [PC_WIDTH-1:0] branch_target,
  output logic                flush,
  output logic                halted,
  output logic                ras_err
);

  localparam logic [PC_WIDTH-1:0] PC_ONE = PC_WIDTH'(1);

  pcseq_state_t r_state;
  pcseq_state_t w_nextState;

  logic                w_callReq;
  logic                w_retReq;
  logic                w_brReq;
  logic                w_push;
  logic                w_pop;
  logic                w_errSet;
  logic [PC_WIDTH-1:0] w_rasTop;
  logic                w_rasFull;
  logic                w_rasEmpty;

`ifdef PC_SEQ_CALL_STACK_EN
  logic                r_rasErr;
  logic [PC_WIDTH-1:0] w_retAddr;

  // Return address wraps modulo 2^PC_WIDTH through the natural width.
  assign w_retAddr = pc + PC_ONE;
  assign w_callReq = call_req;
  assign w_retReq  = ret_req;
  assign w_brReq   = br_req;

  pcseq_ras #(
    .WIDTH (PC_WIDTH),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_retAddr),
    .o_top   (w_rasTop),
    .o_full  (w_rasFull),
    .o_empty (w_rasEmpty)
  );

  // Stack errors are sticky until reset so software can poll them later.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rasErr <= 1'b0;
    end else if (w_errSet) begin
      r_rasErr <= 1'b1;
    end
  end

  assign ras_err = r_rasErr;
`else
  logic w_unusedRas;

  // Without the stack a call is just a jump and a return never happens.
  assign w_callReq   = 1'b0;
  assign w_retReq    = 1'b0;
  assign w_brReq     = br_req | call_req;
  assign w_rasTop    = '0;
  assign w_rasFull   = 1'b0;
  assign w_rasEmpty  = 1'b1;
  assign ras_err     = 1'b0;
  assign w_unusedRas = ^{w_push, w_pop, w_errSet, ret_req, pc};
`endif

  // State register; reset wins over every request, including mid-HALT/FLUSH.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= RUN;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and PC control. In RUN exactly one request acts, chosen by
  // stall > halt > ret > call > br; an empty-stack return falls back to a
  // plain increment and flags the error.
  always_comb begin
    w_nextState   = r_state;
    PCincr        = 1'b0;
    branch_en     = 1'b0;
    branch_target = '0;
    w_push        = 1'b0;
    w_pop         = 1'b0;
    w_errSet      = 1'b0;
    case (r_state)
      RUN: begin
        if (stall_req) begin
          w_nextState = RUN;
        end else if (halt_req) begin
          w_nextState = HALT;
        end else if (w_retReq && !w_rasEmpty) begin
          w_pop         = 1'b1;
          branch_en     = 1'b1;
          branch_target = w_rasTop;
          w_nextState   = FLUSH;
        end else if (w_retReq) begin
          PCincr   = 1'b1;
          w_errSet = 1'b1;
        end else if (w_callReq) begin
          w_push        = 1'b1;
          w_errSet      = w_rasFull;
          branch_en     = 1'b1;
          branch_target = br_target;
          w_nextState   = FLUSH;
        end else if (w_brReq) begin
          branch_en     = 1'b1;
          branch_target = br_target;
          w_nextState   = FLUSH;
        end else begin
          PCincr = 1'b1;
        end
      end
      FLUSH: begin
        PCincr      = !stall_req;
        w_nextState = RUN;
      end
      HALT: begin
        if (resume) begin
          PCincr      = 1'b1;
          w_nextState = RUN;
        end
      end
      default: begin
        w_nextState = RUN;
      end
    endcase
  end

  assign flush  = (r_state == FLUSH);
  assign halted = (r_state == HALT);

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 6, meaning program counter width in bits.
REQ-002 SHALL have parameter RAS_DEPTH, default 4, meaning return-address-stack entries (power of two).
REQ-003 SHALL have port clk  input  1  single system clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port pc  input  PC_WIDTH  current program counter value.
REQ-006 SHALL have port stall_req  input  1  multi-cycle datapath op busy; freeze fetch.
REQ-007 SHALL have port br_req  input  1  taken branch/jump from decode.
REQ-008 SHALL have port br_target  input  PC_WIDTH  target for br_req or call_req.
REQ-009 SHALL have ports call_req and ret_req, each  input  1  subroutine call and return from decode.
REQ-010 SHALL have ports halt_req and resume, each  input  1  enter halt, and leave halt.
REQ-011 SHALL have ports PCincr and branch_en, each  output  1  increment and load controls to the PC register.
REQ-012 SHALL have port branch_target  output  PC_WIDTH  address the PC loads when branch_en=1.
REQ-013 SHALL have ports flush, halted and ras_err, each  output  1  squash the fetched instruction, halt status, and sticky stack error.

Function
REQ-014 SHALL implement FSM states RUN, FLUSH, HALT; PCincr/branch_en/branch_target combinational from state and inputs; flush=1 iff state FLUSH; halted=1 iff state HALT.
REQ-015 SHALL, in RUN, apply priority stall_req > halt_req > ret_req > call_req > br_req > default; only the winner acts.
REQ-016 SHALL, in RUN with stall_req=1, drive PCincr=0 and branch_en=0 and hold state and stack.
REQ-017 SHALL, in RUN with halt_req winning, drive PCincr=0 and branch_en=0; next state HALT.
REQ-018 SHALL, on call_req winning, push (pc+1) mod 2^PC_WIDTH, drive branch_en=1 and branch_target=br_target; next state FLUSH.
REQ-019 SHALL, on ret_req winning with stack non-empty, pop and drive branch_en=1 with branch_target=popped value; next state FLUSH.
REQ-020 SHALL, on br_req winning, drive branch_en=1 and branch_target=br_target; next state FLUSH.
REQ-021 SHALL, in RUN with no request, drive PCincr=1 and branch_en=0.
REQ-022 SHALL hold FLUSH exactly one cycle: ignore br/call/ret/halt, PCincr=!stall_req, branch_en=0; next state RUN regardless of stall_req.
REQ-023 SHALL, in HALT, drive PCincr=0 and branch_en=0 until resume=1; in the resume cycle drive PCincr=1; next state RUN.
REQ-024 SHALL, on a push with the stack full, overwrite the oldest entry and set ras_err.
REQ-025 SHALL, on ret_req with the stack empty, drive PCincr=1 and branch_en=0, stay in RUN, and set ras_err.
REQ-026 SHALL never assert PCincr and branch_en together; branch_target=0 whenever branch_en=0.

Reset
REQ-027 SHALL, with reset=1 at a clock edge, set state RUN, empty the stack, and clear ras_err; reset dominates all inputs, including mid-HALT and mid-FLUSH.
REQ-028 SHALL, in the cycle after reset, present PCincr=1, branch_en=0, flush=0, halted=0, ras_err=0 when no requests are active.

Configuration
REQ-029 SHALL compile the return-address stack only when PC_SEQ_CALL_STACK_EN is defined.
REQ-030 SHALL, without PC_SEQ_CALL_STACK_EN, treat call_req as br_req (no push), treat ret_req as absent, and tie ras_err to 0.

Structure
REQ-031 SHALL take PC_WIDTH, RAS_DEPTH defaults and the state enum pcseq_state_t from cpu_pkg.
REQ-032 SHALL place the stack in sub-module pcseq_ras (push/pop/top/full/empty, circular overwrite), instantiated under the macro.

Verification
REQ-033 SHALL verify reset: assert reset 2 cycles in HALT -> next cycle state RUN, PCincr=1, halted=0, ras_err=0.
REQ-034 SHALL verify branch: pc=0x05, br_req=1, br_target=0x20 -> branch_en=1, target 0x20; next cycle flush=1, PCincr=1; following cycle RUN.
REQ-035 SHALL verify call/ret: call at pc=0x0A to 0x30, later ret -> branch_target=0x0B; call at pc=0x3F pushes 0x00 (wrap).
REQ-036 SHALL verify stack limits: 5 calls with RAS_DEPTH=4 -> ras_err=1, and 4 rets return the newest 4 addresses; a 5th ret -> PCincr=1, no branch.
REQ-037 SHALL verify priority: stall_req=1, br_req=1, halt_req=1 together -> PCincr=0, branch_en=0, no state change; drop stall_req -> HALT; resume -> PCincr=1 that cycle.
REQ-038 SHALL verify the macro undefined: call_req to 0x12 -> branch_en=1, target 0x12; ret_req -> PCincr=1, ras_err=0.
